rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Parametrised register file for the multi-cycle CPU datapath. It provides two combinational read ports and one clocked write port, with a per-register busy scoreboard for in-flight results. After reset, a sequenced initialiser loads every register with its own index before the file reports ready. The block replaces the fixed 4×16 register file and sits between decode (read/issue) and write-back.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 2, address width; NUM_REGS = 2**ADDR_W

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- ready  output  1  high when the init sequence is complete and the file accepts writes/issues
- init_req  input  1  synchronous request to rerun the init sequence (sampled only while ready=1)
- rd_addr1, rd_addr2  input  ADDR_W  read addresses
- rd_data1, rd_data2  output  DATA_W  read data, combinational
- rd_busy1, rd_busy2  output  1  busy bit of the addressed register, combinational
- wr_en  input  1  write-back strobe
- wr_addr  input  ADDR_W  write-back address
- wr_data  input  DATA_W  write-back data
- issue_en  input  1  marks issue_addr as pending
- issue_addr  input  ADDR_W  destination of the newly issued instruction

## Operation
- States: INIT and RUN. A counter `cnt` (ADDR_W+1 bits) is used only in INIT.
- Reset (reset_n=0 at an edge):
  - state=INIT, cnt=0
  - all registers=0, all busy bits=0, ready=0
- INIT:
  - Each edge writes reg[cnt] = cnt (zero-extended or truncated to DATA_W) and increments cnt.
  - On the edge that writes reg[NUM_REGS-1], go to RUN; ready=1 from that edge onward.
  - wr_en, issue_en and init_req are ignored in INIT.
  - Busy bits are all held 0.
- RUN:
  - wr_en=1: reg[wr_addr] ← wr_data, and busy[wr_addr] ← 0.
  - issue_en=1: busy[issue_addr] ← 1.
  - Same-edge wr_en and issue_en to the same address: data is written and busy ends at 1 (issue wins).
  - init_req=1: go to INIT with cnt=0 and busy cleared. Same-edge wr_en and issue_en are discarded.
- Writes to an already-idle register are legal and leave busy=0.
- Issue to an already-busy register is legal and leaves busy=1.
- Reads are combinational in both states. During INIT they return the partially initialised contents.
- reset_n low mid-INIT or mid-RUN restarts from the reset values above at that edge.

## Timing
- Read latency: 0 cycles (combinational from rd_addr* and register state).
- Write and issue effects are visible on reads after the rising edge that samples them.
- Init takes exactly NUM_REGS edges after reset release. With ADDR_W=2, ready rises after the 4th edge.
- An init_req accepted at edge k drops ready from edge k. ready returns after edge k+NUM_REGS.
- Reset values: ready=0. rd_data* = 0 and rd_busy* = 0 for any address until the init writes.

## Configuration
- RF_BYPASS_EN defined:
  - In RUN with wr_en=1, a read port whose address equals wr_addr returns wr_data in the same cycle.
  - That port's rd_busy reads 0, unless issue_en targets the same address in that cycle, in which case it reads 1.
  - No bypass occurs in INIT.
- RF_BYPASS_EN undefined:
  - Reads always return stored register contents and the stored busy bit.
  - The write becomes visible only after the edge.

## Test plan
- Reset then release, ADDR_W=2, DATA_W=16 -> ready=0 for 4 edges, then 1; reg0..3 read 0,1,2,3.
- RUN: issue_en addr 2, next cycle wr_en addr 2 data 0xBEEF -> rd_busy for addr 2 is 1 after the first edge; after the second edge rd_data=0xBEEF and busy=0.
- Same edge: wr_en and issue_en both to addr 1, data 0x1234 -> reg1=0x1234, busy1=1.
- Same-cycle read of addr 3 while writing 0x00AA to it -> with RF_BYPASS_EN, rd_data=0x00AA and busy=0 before the edge; without it, the old value 3.
- Write 0xFFFF to reg0, then init_req -> ready=0 for 4 edges; afterwards reg0=0, all busy=0; a wr_en issued during INIT has no effect.
- reset_n low during the 2nd INIT edge -> registers cleared to 0, and the init restarts from cnt=0.

Source files
------------

// File: rtl/rf_scoreboard_if.sv
// rf_scoreboard_if: decode/write-back side bundle for the register file scoreboard.
// Latency: n/a (wires only); read data/busy are combinational from the slave.
// Backpressure: ready from the slave gates writes/issues; low while the file initialises.
interface rf_scoreboard_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2
);
   logic              ready;
   logic              init_req;
   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_busy1;
   logic              rd_busy2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              issue_en;
   logic [ADDR_W-1:0] issue_addr;

   // decode / write-back side
   modport master (
      input  ready, rd_data1, rd_data2, rd_busy1, rd_busy2,
      output init_req, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr
   );

   // register file side
   modport slave (
      output ready, rd_data1, rd_data2, rd_busy1, rd_busy2,
      input  init_req, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr
   );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: 2R/1W register file with per-register busy bits and a post-reset index initialiser.
// Latency: reads 0 cycles (combinational); write/issue effects visible after the sampling edge.
// Backpressure: ready=0 during the NUM_REGS-edge init; wr_en/issue_en/init_req ignored then.
// Optional macro RF_BYPASS_EN: forwards same-cycle write-back data and busy to matching read ports in RUN.
module rf_scoreboard #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   rf_scoreboard_if.slave bus
);
   localparam int NUM_REGS = 2**ADDR_W;

   typedef enum logic {INIT, RUN} state_t;

   state_t                          state;
   state_t                          state_nxt;
   logic [ADDR_W:0]                 cnt;
   logic [ADDR_W:0]                 cnt_nxt;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [NUM_REGS-1:0]             busy;

   assign bus.ready = (state == RUN);

   // state and init counter register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next state: INIT walks cnt over every register, RUN waits for an init request
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         INIT: begin
            cnt_nxt = cnt + (ADDR_W+1)'(1);
            if (cnt == (ADDR_W+1)'(NUM_REGS-1)) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            if (bus.init_req) begin
               state_nxt = INIT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = INIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   // register and busy update; in RUN the issue assignment comes last so it wins over write-back
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         regs <= '0;
         busy <= '0;
      end else if (state == INIT) begin
         regs[cnt[ADDR_W-1:0]] <= DATA_W'(cnt);
         busy                  <= '0;
      end else if (bus.init_req) begin
         busy <= '0;
      end else begin
         if (bus.wr_en) begin
            regs[bus.wr_addr] <= bus.wr_data;
            busy[bus.wr_addr] <= 1'b0;
         end
         if (bus.issue_en) begin
            busy[bus.issue_addr] <= 1'b1;
         end
      end
   end

   // read ports: stored contents, optionally forwarded from the write-back in flight
   always_comb begin
      bus.rd_data1 = regs[bus.rd_addr1];
      bus.rd_busy1 = busy[bus.rd_addr1];
      bus.rd_data2 = regs[bus.rd_addr2];
      bus.rd_busy2 = busy[bus.rd_addr2];
`ifdef RF_BYPASS_EN
      if ((state == RUN) && bus.wr_en && (bus.rd_addr1 == bus.wr_addr)) begin
         bus.rd_data1 = bus.wr_data;
         bus.rd_busy1 = bus.issue_en && (bus.issue_addr == bus.wr_addr);
      end
      if ((state == RUN) && bus.wr_en && (bus.rd_addr2 == bus.wr_addr)) begin
         bus.rd_data2 = bus.wr_data;
         bus.rd_busy2 = bus.issue_en && (bus.issue_addr == bus.wr_addr);
      end
`endif
   end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed checks of init sequencing, write/issue scoreboard and init_req/reset restarts.
// Inputs change 2ns after the rising edge; outputs are sampled 1ns after each input change.
// Expected values are hand-computed constants; bypass expectations follow RF_BYPASS_EN.
module tb_rf_scoreboard;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 2;
`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   rf_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   rf_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // read one register through both ports
   task automatic chk_reg(input string tag, input logic [1:0] a, input logic [15:0] d, input logic b);
      bus.rd_addr1 = a;
      bus.rd_addr2 = a;
      #1;
      chk16({tag, "_d1"}, bus.rd_data1, d);
      chk16({tag, "_d2"}, bus.rd_data2, d);
      chk1({tag, "_b1"}, bus.rd_busy1, b);
      chk1({tag, "_b2"}, bus.rd_busy2, b);
   endtask

   // read all four registers, port 1 ascending, port 2 descending
   task automatic chk_all(input string tag, input logic [3:0][15:0] d, input logic [3:0] b);
      for (int i = 0; i < 4; i++) begin
         bus.rd_addr1 = 2'(i);
         bus.rd_addr2 = 2'(3 - i);
         #1;
         chk16($sformatf("%s_d1_r%0d", tag, i), bus.rd_data1, d[i]);
         chk16($sformatf("%s_d2_r%0d", tag, 3 - i), bus.rd_data2, d[3 - i]);
         chk1($sformatf("%s_b1_r%0d", tag, i), bus.rd_busy1, b[i]);
         chk1($sformatf("%s_b2_r%0d", tag, 3 - i), bus.rd_busy2, b[3 - i]);
      end
   endtask

   task automatic idle_inputs();
      bus.init_req   = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.issue_en   = 1'b0;
      bus.issue_addr = '0;
   endtask

   initial begin
      idle_inputs();
      bus.rd_addr1 = '0;
      bus.rd_addr2 = '0;

      // reset state
      reset_n = 1'b0;
      tick();
      tick();
      chk1("rst_ready", bus.ready, 1'b0);
      chk_all("rst", {16'h0, 16'h0, 16'h0, 16'h0}, 4'b0000);

      // init after release: ready low for 4 edges, partial contents visible
      reset_n = 1'b1;
      tick();
      chk1("init_e1_ready", bus.ready, 1'b0);
      chk_reg("init_e1_r1", 2'd1, 16'h0000, 1'b0);
      tick();
      tick();
      chk1("init_e3_ready", bus.ready, 1'b0);
      chk_reg("init_e3_r2", 2'd2, 16'h0002, 1'b0);
      chk_reg("init_e3_r3", 2'd3, 16'h0000, 1'b0);
      tick();
      chk1("init_e4_ready", bus.ready, 1'b1);
      chk_all("init_done", {16'h3, 16'h2, 16'h1, 16'h0}, 4'b0000);

      // issue to reg2, then write-back to reg2
      bus.issue_en = 1'b1; bus.issue_addr = 2'd2;
      tick();
      idle_inputs();
      chk_reg("iss2", 2'd2, 16'h0002, 1'b1);
      bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 16'hBEEF;
      bus.rd_addr1 = 2'd2;
      #1;
      chk16("byp_wb2_d", bus.rd_data1, BYP ? 16'hBEEF : 16'h0002);
      chk1("byp_wb2_b", bus.rd_busy1, BYP ? 1'b0 : 1'b1);
      tick();
      idle_inputs();
      chk_reg("wb2", 2'd2, 16'hBEEF, 1'b0);

      // same-edge write and issue to reg1: data lands, issue wins on busy
      bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 16'h1234;
      bus.issue_en = 1'b1; bus.issue_addr = 2'd1;
      bus.rd_addr1 = 2'd1;
      #1;
      chk16("byp_wi1_d", bus.rd_data1, BYP ? 16'h1234 : 16'h0001);
      chk1("byp_wi1_b", bus.rd_busy1, BYP ? 1'b1 : 1'b0);
      tick();
      idle_inputs();
      chk_reg("wi1", 2'd1, 16'h1234, 1'b1);

      // same-cycle read of reg3 while writing it; port 2 on another register is untouched
      bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 16'h00AA;
      bus.rd_addr1 = 2'd3;
      bus.rd_addr2 = 2'd0;
      #1;
      chk16("byp_w3_d", bus.rd_data1, BYP ? 16'h00AA : 16'h0003);
      chk1("byp_w3_b", bus.rd_busy1, 1'b0);
      chk16("byp_w3_other", bus.rd_data2, 16'h0000);
      tick();
      idle_inputs();
      chk_reg("w3", 2'd3, 16'h00AA, 1'b0);

      // issue to an already-busy register, write to an idle register
      bus.issue_en = 1'b1; bus.issue_addr = 2'd1;
      bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 16'hFFFF;
      tick();
      idle_inputs();
      chk_reg("reiss1", 2'd1, 16'h1234, 1'b1);
      chk_reg("idle_w0", 2'd0, 16'hFFFF, 1'b0);

      // init_req with same-edge write/issue: both discarded, busy cleared, ready drops
      bus.init_req = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 16'h5555;
      bus.issue_en = 1'b1; bus.issue_addr = 2'd3;
      tick();
      idle_inputs();
      chk1("ireq_k_ready", bus.ready, 1'b0);
      chk_reg("ireq_k_r2", 2'd2, 16'hBEEF, 1'b0);
      chk_reg("ireq_k_r1", 2'd1, 16'h1234, 1'b0);
      chk_reg("ireq_k_r3", 2'd3, 16'h00AA, 1'b0);

      // writes, issues and init_req held during INIT are ignored, and never bypassed
      bus.init_req = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 16'h7777;
      bus.issue_en = 1'b1; bus.issue_addr = 2'd0;
      tick();
      chk1("ireq_k1_ready", bus.ready, 1'b0);
      bus.rd_addr1 = 2'd0;
      #1;
      chk16("ireq_k1_nobyp_d", bus.rd_data1, 16'h0000);
      chk1("ireq_k1_nobyp_b", bus.rd_busy1, 1'b0);
      tick();
      tick();
      chk1("ireq_k3_ready", bus.ready, 1'b0);
      idle_inputs();
      tick();
      chk1("ireq_k4_ready", bus.ready, 1'b1);
      chk_all("ireq_done", {16'h3, 16'h2, 16'h1, 16'h0}, 4'b0000);

      // reset asserted on the second INIT edge clears registers and restarts init
      bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 16'hAAAA;
      tick();
      idle_inputs();
      bus.init_req = 1'b1;
      tick();
      idle_inputs();
      tick();
      reset_n = 1'b0;
      tick();
      chk1("rst_mid_ready", bus.ready, 1'b0);
      chk_all("rst_mid", {16'h0, 16'h0, 16'h0, 16'h0}, 4'b0000);
      reset_n = 1'b1;
      tick();
      tick();
      chk_reg("rst_re2_r1", 2'd1, 16'h0001, 1'b0);
      chk_reg("rst_re2_r2", 2'd2, 16'h0000, 1'b0);
      tick();
      chk1("rst_re3_ready", bus.ready, 1'b0);
      tick();
      chk1("rst_re4_ready", bus.ready, 1'b1);
      chk_all("rst_re_done", {16'h3, 16'h2, 16'h1, 16'h0}, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
